// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mult/div op encoding, mult/div FSM states,
// and the R-type function codes that route to the HI/LO unit.
package mips_pkg;

    // function_code[1:0] of MULT/MULTU/DIV/DIVU
    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

    localparam logic [5:0] FUNCT_MFHI = 6'd16;
    localparam logic [5:0] FUNCT_MTHI = 6'd17;
    localparam logic [5:0] FUNCT_MFLO = 6'd18;
    localparam logic [5:0] FUNCT_MTLO = 6'd19;
    localparam logic [5:0] FUNCT_MULT = 6'd24;
    localparam logic [5:0] FUNCT_DIVU = 6'd27;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction for the iterative mult/div datapath. The core
// works on magnitudes only; this block turns the raw {hi,lo} magnitude
// result into the architectural HI/LO values.
module muldiv_sign_fix
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] raw,
    input  muldiv_op_t         op,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic               div_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] neg_raw;
    logic [WIDTH-1:0]   neg_rem;
    logic [WIDTH-1:0]   neg_quo;

    assign neg_raw = -raw;
    assign neg_rem = -raw[2*WIDTH-1:WIDTH];
    assign neg_quo = -raw[WIDTH-1:0];

    // Product negates as a whole; quotient follows sign_a^sign_b, remainder
    // follows the dividend. Divide by zero always reports LO = all ones.
    always_comb begin
        hi = raw[2*WIDTH-1:WIDTH];
        lo = raw[WIDTH-1:0];
        case (op)
            MULT: begin
                if (sign_a ^ sign_b) {hi, lo} = neg_raw;
            end
            DIV: begin
                if (sign_a) hi = neg_rem;
                if (sign_a ^ sign_b) lo = neg_quo;
                if (div_zero) lo = '1;
            end
            DIVU: begin
                if (div_zero) lo = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with the HI/LO register pair.
// One shift-add or restoring-subtract step per cycle, WIDTH+1 cycles per op.
// Optional: define MULDIV_FAST_MULT_EN for single-cycle MULT/MULTU.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_wren,
    input  logic             lo_wren,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall_req
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t    state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;   // running {hi,lo}: product, or {remainder, quotient}
    logic [WIDTH-1:0] opb_q;                // multiplicand (mult) or divisor (div) magnitude
    logic [WIDTH-1:0] hi_q, lo_q;
    muldiv_op_t       op_q;
    logic             sign_a_q, sign_b_q, div0_q;

    logic             is_signed, is_div, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             start_ok, mt_any, launch_iter;
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    // Decoder raises hi/lo_wren alongside multdiv, so start masks the MT strobes.
    assign start_ok = start && (state_q == IDLE);
    assign mt_any   = !start && (hi_wren || lo_wren);

    assign is_signed = !op[0];
    assign is_div    = op[1];
    assign neg_a     = is_signed && operand_a[WIDTH-1];
    assign neg_b     = is_signed && operand_b[WIDTH-1];
    assign mag_a     = neg_a ? -operand_a : operand_a;
    assign mag_b     = neg_b ? -operand_b : operand_b;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
    assign ext_a       = is_signed ? {{WIDTH{operand_a[WIDTH-1]}}, operand_a} : {{WIDTH{1'b0}}, operand_a};
    assign ext_b       = is_signed ? {{WIDTH{operand_b[WIDTH-1]}}, operand_b} : {{WIDTH{1'b0}}, operand_b};
    assign fast_prod   = ext_a * ext_b;
    assign launch_iter = start_ok && is_div;
`else
    assign launch_iter = start_ok;
`endif

    // Single iteration step for both algorithms.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ok   = (div_sh >= {1'b0, opb_q});
        div_diff = div_sh[WIDTH-1:0] - opb_q;
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .raw      ({acc_hi_q, acc_lo_q}),
        .op       (op_q),
        .sign_a   (sign_a_q),
        .sign_b   (sign_b_q),
        .div_zero (div0_q),
        .hi       (fix_hi),
        .lo       (fix_lo)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; an MT write cancels whatever is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch_iter) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (mt_any) state_d = IDLE;
    end

    // Datapath, counter and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_iter) begin
                        acc_hi_q <= '0;
                        acc_lo_q <= is_div ? mag_a : mag_b;
                        opb_q    <= is_div ? mag_b : mag_a;
                        op_q     <= muldiv_op_t'(op);
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        div0_q   <= is_div && (operand_b == '0);
                        cnt_q    <= CW'(WIDTH);
                    end
`ifdef MULDIV_FAST_MULT_EN
                    else if (start_ok) begin
                        hi_q <= fast_prod[2*WIDTH-1:WIDTH];
                        lo_q <= fast_prod[WIDTH-1:0];
                    end
`endif
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q[1]) begin
                        acc_hi_q <= div_ok ? div_diff : div_sh[WIDTH-1:0];
                        acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ok};
                    end else begin
                        acc_hi_q <= mul_sum[WIDTH:1];
                        acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
            if (mt_any) begin
                if (hi_wren) hi_q <= mt_data;
                if (lo_wren) lo_q <= mt_data;
            end
        end
    end

    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign busy      = (state_q != IDLE);
    assign stall_req = busy && mf_req;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic reference.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    // An op that stays iterative in every build
    localparam logic [1:0] LONG_OP = FAST ? 2'b10 : 2'b00;

    logic          clk = 1'b0;
    logic          reset, start, hi_wren, lo_wren, mf_req;
    logic [1:0]    op;
    logic [W-1:0]  operand_a, operand_b, mt_data, hi_out, lo_out;
    logic          busy, stall_req;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi_wren   (hi_wren),
        .lo_wren   (lo_wren),
        .mt_data   (mt_data),
        .mf_req    (mf_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out),
        .busy      (busy),
        .stall_req (stall_req)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {HI, LO} from MIPS arithmetic rules
    function automatic logic [63:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int lat(logic [1:0] o);
        return (FAST && !o[1]) ? 0 : W + 1;
    endfunction

    task automatic run_op(string tag, logic [1:0] o, logic [31:0] a, logic [31:0] b);
        logic [63:0] e;
        int n;
        e = model(o, a, b);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin n++; cyc(); end
        chk({tag, ".lat"}, 64'(n), 64'(lat(o)));
        chk({tag, ".hi"}, {32'b0, hi_out}, {32'b0, e[63:32]});
        chk({tag, ".lo"}, {32'b0, lo_out}, {32'b0, e[31:0]});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] e;
        logic [31:0] prev_hi, prev_lo;
        int L;

        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
        hi_wren = 1'b0; lo_wren = 1'b0; mt_data = '0; mf_req = 1'b0;
        cyc(); cyc();
        chk("rst.hi", {32'b0, hi_out}, 64'h0);
        chk("rst.lo", {32'b0, lo_out}, 64'h0);
        chk("rst.busy", {63'b0, busy}, 64'h0);
        reset = 1'b0;
        cyc();

        // Directed vectors
        run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        chk("mult_neg3x5.hi_const", {32'b0, hi_out}, 64'hFFFF_FFFF);
        chk("mult_neg3x5.lo_const", {32'b0, lo_out}, 64'hFFFF_FFF1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max.hi_const", {32'b0, hi_out}, 64'hFFFF_FFFE);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
        chk("mult_min.hi_const", {32'b0, hi_out}, 64'h4000_0000);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg7_2.lo_const", {32'b0, lo_out}, 64'hFFFF_FFFD);
        run_op("divu_by0", 2'b11, 32'd7, 32'd0);
        chk("divu_by0.hi_const", {32'b0, hi_out}, 64'h7);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

        // Random ops
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), pick(), pick());
        end

        // Stall: mf_req held from cycle 5 of a multiply until it finishes
        e = model(2'b00, 32'd1234567, 32'hFFFF_0001);
        L = lat(2'b00);
        op = 2'b00; operand_a = 32'd1234567; operand_b = 32'hFFFF_0001; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= L; k++) begin
            mf_req = (k >= 5);
            #1;
            chk($sformatf("stall.k%0d", k), {63'b0, stall_req}, {63'b0, (k >= 5) && (k < L)});
            if (k == L) begin
                chk("stall.lo", {32'b0, lo_out}, {32'b0, e[31:0]});
                chk("stall.hi", {32'b0, hi_out}, {32'b0, e[63:32]});
            end else begin
                cyc();
            end
        end
        mf_req = 1'b0;

        // MTHI+MTLO together, then start with both wren high must not write mt_data
        hi_wren = 1'b1; lo_wren = 1'b1; mt_data = 32'hA5A5_A5A5;
        cyc();
        hi_wren = 1'b0; lo_wren = 1'b0;
        chk("mt_both.hi", {32'b0, hi_out}, 64'hA5A5_A5A5);
        chk("mt_both.lo", {32'b0, lo_out}, 64'hA5A5_A5A5);
        prev_hi = 32'hA5A5_A5A5; prev_lo = 32'hA5A5_A5A5;
        e = model(2'b00, 32'd3, 32'd4);
        op = 2'b00; operand_a = 32'd3; operand_b = 32'd4;
        start = 1'b1; hi_wren = 1'b1; lo_wren = 1'b1; mt_data = 32'hDEAD_BEEF;
        cyc();
        start = 1'b0; hi_wren = 1'b0; lo_wren = 1'b0;
        chk("start_wren.hi0", {32'b0, hi_out}, {32'b0, FAST ? e[63:32] : prev_hi});
        chk("start_wren.lo0", {32'b0, lo_out}, {32'b0, FAST ? e[31:0] : prev_lo});
        for (int n = 0; n < 200 && busy; n++) cyc();
        chk("start_wren.lo", {32'b0, lo_out}, {32'b0, e[31:0]});

        // MTLO while DIVU in flight cancels it; HI keeps its pre-op value
        hi_wren = 1'b1; mt_data = 32'h5555_AAAA;
        cyc();
        hi_wren = 1'b0;
        op = 2'b11; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 10; n++) cyc();
        chk("mtlo_cancel.busy_before", {63'b0, busy}, 64'h1);
        lo_wren = 1'b1; mt_data = 32'h0000_1234;
        cyc();
        lo_wren = 1'b0;
        chk("mtlo_cancel.lo", {32'b0, lo_out}, 64'h1234);
        chk("mtlo_cancel.hi", {32'b0, hi_out}, 64'h5555_AAAA);
        chk("mtlo_cancel.busy", {63'b0, busy}, 64'h0);

        // Reset mid-operation clears HI/LO and busy without a clock edge
        op = LONG_OP; operand_a = 32'd99; operand_b = 32'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int n = 0; n < 14; n++) cyc();
        chk("midrst.busy_before", {63'b0, busy}, 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.hi", {32'b0, hi_out}, 64'h0);
        chk("midrst.lo", {32'b0, lo_out}, 64'h0);
        chk("midrst.busy", {63'b0, busy}, 64'h0);
        cyc();
        reset = 1'b0;
        cyc();

        // Unit still works after the abort
        run_op("post_rst_divu", 2'b11, 32'd1000, 32'd33);

`ifdef MULDIV_FAST_MULT_EN
        op = 2'b00; operand_a = 32'd6; operand_b = 32'd7; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("fast.lo", {32'b0, lo_out}, 64'd42);
        chk("fast.busy", {63'b0, busy}, 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
